// File: rtl/agex_muldiv_unit.sv
// rtl/agex_muldiv_unit.sv - iterative RISC-V M-extension multiply/divide execute unit
module agex_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int ITER  = XLEN / UNROLL;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;

    logic              accept;
    logic              a_signed, b_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_data;

    logic [XLEN-1:0]   step_hi, step_lo;
    logic [XLEN:0]     rem_t, sum_t;

    logic [2*XLEN-1:0] prod_n;
    logic [XLEN-1:0]   quo_n, rem_n;
    logic [XLEN-1:0]   fix_result;

    assign req_ready = (state == IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    // Signed operands: MULH/DIV/REM both, MULHSU only rs1.
    assign a_signed = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
    assign b_signed = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
    assign a_neg    = a_signed && req_a[XLEN-1];
    assign b_neg    = b_signed && req_b[XLEN-1];
    assign a_mag    = a_neg ? (~req_a + 1'b1) : req_a;
    assign b_mag    = b_neg ? (~req_b + 1'b1) : req_b;

    assign div_zero = req_op[2] && (req_b == '0);
    assign div_ovf  = ((req_op == 3'd4) || (req_op == 3'd6)) &&
                      (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);

    always_comb begin
        special_data = '0;
        if (div_zero)
            special_data = req_op[1] ? req_a : '1;
        else if (div_ovf)
            special_data = req_op[1] ? '0 : req_a;
    end

    // One iteration retires UNROLL bits: shift-add for multiply, restoring step for divide.
    always_comb begin
        step_hi = hi;
        step_lo = lo;
        rem_t   = '0;
        sum_t   = '0;
        for (int j = 0; j < UNROLL; j++) begin
            if (op_q[2]) begin
                rem_t   = {step_hi, step_lo[XLEN-1]};
                step_lo = {step_lo[XLEN-2:0], 1'b0};
                if (rem_t >= {1'b0, opnd}) begin
                    rem_t      = rem_t - {1'b0, opnd};
                    step_lo[0] = 1'b1;
                end
                step_hi = rem_t[XLEN-1:0];
            end else begin
                sum_t              = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
                {step_hi, step_lo} = {sum_t, step_lo[XLEN-1:1]};
            end
        end
    end

    assign prod_n = neg_q ? (~{hi, lo} + 1'b1) : {hi, lo};
    assign quo_n  = neg_q ? (~lo + 1'b1) : lo;
    assign rem_n  = neg_q ? (~hi + 1'b1) : hi;

    always_comb begin
        case (op_q)
            3'd0:          fix_result = prod_n[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fix_result = prod_n[2*XLEN-1:XLEN];
            3'd4, 3'd5:    fix_result = quo_n;
            default:       fix_result = rem_n;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            opnd       <= '0;
            hi         <= '0;
            lo         <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= req_op;
                        resp_tag <= req_tag;
                        busy     <= 1'b1;
                        // REM result follows the dividend; everything else is the xor of signs.
                        neg_q    <= (req_op == 3'd6) ? a_neg : (a_neg ^ b_neg);
                        hi       <= '0;
                        lo       <= req_op[2] ? a_mag : b_mag;
                        opnd     <= req_op[2] ? b_mag : a_mag;
                        if (div_zero || div_ovf) begin
                            state      <= DONE;
                            resp_data  <= special_data;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_W'(ITER);
                        end
                    end
                end
                CALC: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= FIX;
                end
                FIX: begin
                    resp_data  <= fix_result;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agex_muldiv_unit.sv
// tb/tb_agex_muldiv_unit.sv - directed vector bench for agex_muldiv_unit
module tb_agex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_tag;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    agex_muldiv_unit #(.XLEN(32), .UNROLL(1), .TAG_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accept edge counts as cycle 1; returns cycles until resp_valid is seen, leaves result pending.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int lat, output logic busy_ok);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        lat       = 1;
        busy_ok   = 1'b1;
        while (!resp_valid && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        bok;
        logic [31:0] d_hold;
        logic [4:0]  t_hold;
        int          seen;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 34};
        vecs[2]  = '{3'd3, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 34};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       34};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        34};
        vecs[8]  = '{3'd5, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,        32'd0,        5'd10, 32'd5,        1};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1};
        vecs[12] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, 34};
        vecs[13] = '{3'd0, 32'h00010000, 32'h00010000, 5'd14, 32'd0,        34};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = 32'h0;
        req_b      = 32'h0;
        req_tag    = 5'd0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_busy",       {31'b0, busy},       32'd0);
        chk("rst_resp_data",  resp_data,           32'd0);
        chk("rst_resp_tag",   {27'b0, resp_tag},   32'd0);
        chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, lat, bok);
            chk($sformatf("v%0d_data", i),    resp_data,           vecs[i].exp);
            chk($sformatf("v%0d_tag", i),     {27'b0, resp_tag},   {27'b0, vecs[i].tag});
            chk($sformatf("v%0d_latency", i), lat,                 vecs[i].lat);
            chk($sformatf("v%0d_busy", i),    {31'b0, bok},        32'd1);
            consume();
            chk($sformatf("v%0d_released", i), {30'b0, resp_valid, busy}, 32'd0);
        end

        // Flush during CALC: result is discarded and the unit is immediately reusable.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd3; req_b = 32'd4; req_tag = 5'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_busy",       {31'b0, busy},       32'd0);
        chk("flush_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_req_ready", {31'b0, req_ready}, 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        chk("flush_no_resp", seen, 0);

        // Flush held with a pending request must block the accept.
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd5; req_a = 32'd9; req_b = 32'd3;
        #1;
        chk("flush_blocks_ready", {31'b0, req_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_accept", {31'b0, busy}, 32'd0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;

        // Back-pressure in DONE holds the result stable.
        issue(3'd5, 32'd100, 32'd7, 5'd17, lat, bok);
        d_hold = resp_data;
        t_hold = resp_tag;
        chk("stall_first_data", resp_data, 32'd14);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (!resp_valid || resp_data !== d_hold || resp_tag !== t_hold) seen++;
        end
        chk("stall_stable", seen, 0);
        chk("stall_tag", {27'b0, resp_tag}, 32'd17);
        consume();
        chk("stall_release_valid", {31'b0, resp_valid}, 32'd0);
        chk("stall_release_ready", {31'b0, req_ready},  32'd1);

        // Flush in DONE drops the pending result.
        issue(3'd4, 32'd5, 32'd0, 5'd21, lat, bok);
        @(negedge clk);
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_done_valid", {31'b0, resp_valid}, 32'd0);
        chk("flush_done_data",  resp_data, 32'hFFFFFFFF);
        @(negedge clk);
        flush = 1'b0; resp_ready = 1'b0;

        // Asynchronous reset mid-CALC, asserted away from any clock edge.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'd11; req_b = 32'd13; req_tag = 5'd30;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_areset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("areset_busy",       {31'b0, busy},       32'd0);
        chk("areset_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("areset_resp_data",  resp_data,           32'd0);
        chk("areset_resp_tag",   {27'b0, resp_tag},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        chk("areset_no_resp", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
